// File: rtl/irq_sched.sv
// -----------------------------------------------------------------------------
// irq_sched
//
// Sits between the interrupt gateway array and the CPU. It picks the
// highest-priority pending and enabled source that is above the threshold and
// raises irq for it. It then runs the claim -> service -> complete handshake,
// which sends one-hot claim/complete pulses back to the gateway that owns the
// source.
//
// Parameters
//   NSRC    number of sources (IDs 1..NSRC; ID 0 = none). At most 12, because
//           the priority registers occupy word indexes 0x2..0xD.
//   PRIO_W  priority / threshold width.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   src_ip            pending bits from the gateways (bit i = ID i+1)
//   cfg_we/addr/wdata word-addressed register write port
//   cfg_rdata         combinational read data for cfg_addr
//   claim_req         CPU claim strobe; answered next cycle on claim_valid/id
//   complete_req/id   CPU completion strobe and the ID being completed
//   irq               interrupt request to the core (registered)
//   gw_claim          one-cycle one-hot claim pulse to the owning gateway
//   gw_complete       one-cycle one-hot complete pulse to the owning gateway
//
// Register map: 0x0 enable, 0x1 threshold, 0x2+i priority of ID i+1,
//               0xE status {active ID[15:8], err[0]} (write clears err),
//               0xF raw src_ip.
// -----------------------------------------------------------------------------
module irq_sched #(
    parameter int NSRC   = 2,
    parameter int PRIO_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   src_ip,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic [31:0]       cfg_rdata,
    input  logic              claim_req,
    output logic              claim_valid,
    output logic [7:0]        claim_id,
    input  logic              complete_req,
    input  logic [7:0]        complete_id,
    output logic              irq,
    output logic [NSRC-1:0]   gw_claim,
    output logic [NSRC-1:0]   gw_complete
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_SERV = 2'd2
    } state_t;

    // Configuration registers
    logic [NSRC-1:0]   enable_reg;
    logic [PRIO_W-1:0] thresh_reg;
    logic [PRIO_W-1:0] prio_reg [NSRC];

    // Sequencer state
    state_t            state_reg, state_next;
    logic [7:0]        cur_id_reg, cur_id_next;
    logic [PRIO_W-1:0] cur_prio_reg, cur_prio_next;
    logic [7:0]        active_id_reg, active_id_next;
    logic              err_reg, err_next;

    // Registered outputs
    logic              irq_reg, irq_next;
    logic              claim_valid_reg;
    logic [7:0]        claim_id_reg, claim_id_next;
    logic [NSRC-1:0]   gw_claim_reg, gw_claim_next;
    logic [NSRC-1:0]   gw_complete_reg, gw_complete_next;

    // Arbitration
    logic [NSRC-1:0]   eligible;
    logic              win_valid;
    logic [7:0]        win_id;
    logic [PRIO_W-1:0] win_prio;

    logic              claim_take;
    logic              complete_take;

    // The latched priority is kept for visibility only. Upper write-data bits
    // are not mapped anywhere.
    logic              unused_bits;
    assign unused_bits = ^{cfg_wdata, cur_prio_reg};

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_reg <= '0;
            thresh_reg <= '0;
            for (int i = 0; i < NSRC; i++) begin
                prio_reg[i] <= '0;
            end
        end else if (cfg_we) begin
            if (cfg_addr == 4'h0) enable_reg <= cfg_wdata[NSRC-1:0];
            if (cfg_addr == 4'h1) thresh_reg <= cfg_wdata[PRIO_W-1:0];
            for (int i = 0; i < NSRC; i++) begin
                if (cfg_addr == 4'(i + 2)) prio_reg[i] <= cfg_wdata[PRIO_W-1:0];
            end
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            4'h0:    cfg_rdata = 32'(enable_reg);
            4'h1:    cfg_rdata = 32'(thresh_reg);
            4'hE:    cfg_rdata = {16'd0, active_id_reg, 7'd0, err_reg};
            4'hF:    cfg_rdata = 32'(src_ip);
            default: begin
                for (int i = 0; i < NSRC; i++) begin
                    if (cfg_addr == 4'(i + 2)) cfg_rdata = 32'(prio_reg[i]);
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-source eligibility and one-hot pulse decode
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        // Strictly greater than the threshold, so priority 0 never fires.
        assign eligible[gi] = src_ip[gi] & enable_reg[gi] & (prio_reg[gi] > thresh_reg);
        assign gw_claim_next[gi]    = claim_take    & (cur_id_reg    == 8'(gi + 1));
        assign gw_complete_next[gi] = complete_take & (active_id_reg == 8'(gi + 1));
    end

    // Winner scan: replace only on a strictly higher priority, so the lowest
    // ID wins a tie.
    always_comb begin
        win_valid = 1'b0;
        win_id    = 8'd0;
        win_prio  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (eligible[i] && (!win_valid || (prio_reg[i] > win_prio))) begin
                win_valid = 1'b1;
                win_id    = 8'(i + 1);
                win_prio  = prio_reg[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Claim / complete sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        cur_id_next    = cur_id_reg;
        cur_prio_next  = cur_prio_reg;
        active_id_next = active_id_reg;
        err_next       = err_reg;
        claim_id_next  = 8'd0;
        claim_take     = 1'b0;
        complete_take  = 1'b0;

        // Writing the status word clears err. An error raised in the same
        // cycle below still takes precedence.
        if (cfg_we && (cfg_addr == 4'hE)) err_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (complete_req) err_next = 1'b1;
                if (win_valid) begin
                    state_next    = ST_PEND;
                    cur_id_next   = win_id;
                    cur_prio_next = win_prio;
                end
            end
            ST_PEND: begin
                if (complete_req) err_next = 1'b1;
                // A simultaneous complete takes precedence; the claim then
                // returns 0.
                if (claim_req && !complete_req) begin
                    claim_take     = 1'b1;
                    claim_id_next  = cur_id_reg;
                    active_id_next = cur_id_reg;
                    state_next     = ST_SERV;
                end else if (win_valid) begin
                    cur_id_next   = win_id;
                    cur_prio_next = win_prio;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SERV: begin
                // No preemption: arbitration is ignored until completion.
                if (complete_req) begin
                    if (complete_id == active_id_reg) begin
                        complete_take  = 1'b1;
                        active_id_next = 8'd0;
                        state_next     = ST_IDLE;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        irq_next = (state_next == ST_PEND);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            cur_id_reg      <= 8'd0;
            cur_prio_reg    <= '0;
            active_id_reg   <= 8'd0;
            err_reg         <= 1'b0;
            irq_reg         <= 1'b0;
            claim_valid_reg <= 1'b0;
            claim_id_reg    <= 8'd0;
            gw_claim_reg    <= '0;
            gw_complete_reg <= '0;
        end else begin
            state_reg       <= state_next;
            cur_id_reg      <= cur_id_next;
            cur_prio_reg    <= cur_prio_next;
            active_id_reg   <= active_id_next;
            err_reg         <= err_next;
            irq_reg         <= irq_next;
            claim_valid_reg <= claim_req;
            claim_id_reg    <= claim_id_next;
            gw_claim_reg    <= gw_claim_next;
            gw_complete_reg <= gw_complete_next;
        end
    end

    assign irq         = irq_reg;
    assign claim_valid = claim_valid_reg;
    assign claim_id    = claim_id_reg;
    assign gw_claim    = gw_claim_reg;
    assign gw_complete = gw_complete_reg;

endmodule

// File: doc/irq_sched.md
# irq_sched

Priority scheduler and claim/complete sequencer between the interrupt gateways and the CPU. It samples the gateways' pending bits and applies per-source enable, priority and a global threshold. It asserts one interrupt line to the core, and runs the claim → service → complete handshake by issuing one-hot claim/complete pulses back to the owning gateway. The block sits above the gateway array; its configuration is programmed over a simple word-addressed register port.

## Interface
- NSRC, 2: number of interrupt sources; IDs are 1..NSRC, ID 0 means "none".
- PRIO_W, 3: priority / threshold width.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- src_ip  input  NSRC  pending bits from the gateways; bit i is ID i+1.
- cfg_we  input  1  register write strobe.
- cfg_addr  input  4  word index.
- cfg_wdata  input  32  write data.
- cfg_rdata  output  32  combinational read data for cfg_addr.
- claim_req  input  1  single-cycle CPU claim read.
- claim_valid  output  1  registered one-cycle response to claim_req.
- claim_id  output  8  claimed ID, valid with claim_valid; 0 means nothing claimable.
- complete_req  input  1  single-cycle CPU completion.
- complete_id  input  8  ID being completed.
- irq  output  1  interrupt request to the core.
- gw_claim  output  NSRC  one-hot, one-cycle claim pulse to a gateway.
- gw_complete  output  NSRC  one-hot, one-cycle complete pulse to a gateway.

## Operation
- Register map (word index):
  - 0x0 is the enable mask, bits [NSRC-1:0].
  - 0x1 is the threshold, bits [PRIO_W-1:0].
  - 0x2+i is the priority of ID i+1.
  - 0xE is read-only status: bit0 = sticky err, bits[15:8] = active ID. A write to 0xE clears err.
  - 0xF is read-only raw src_ip.
  - Unused bits read 0. Writes to unmapped addresses are ignored.
- Eligibility: a source is eligible when src_ip & enable is set and priority > threshold (strictly greater). Priority 0 therefore never interrupts.
- Winner: the highest priority among eligible sources. Ties go to the lowest ID. This is a combinational compare tree over NSRC.
- FSM states:
  - IDLE (irq=0): each cycle, if a winner exists, latch cur_id/cur_prio and go to PEND.
  - PEND (irq=1): re-arbitrate every cycle and update cur_id when the winner changes. With no eligible source, go to IDLE.
  - On claim_req in PEND, return cur_id as registered at that edge and pulse gw_claim[cur_id-1]. The active ID becomes cur_id; go to SERV.
  - SERV (irq=0): no preemption and no nesting.
  - On complete_req with complete_id == active ID in SERV, pulse gw_complete[active-1], clear the active ID to 0, and go to IDLE.
- Error handling:
  - complete_req with a mismatched ID, or in IDLE/PEND, is ignored and sets err.
  - claim_req in IDLE or SERV returns claim_id=0 with no gw_claim pulse, and the state is unchanged.
- claim_req and complete_req in the same cycle: complete is processed; claim returns 0.
- Configuration writes take effect in the next cycle's arbitration.
  - Disabling or lowering the priority of the active source in SERV does not abort service.
  - In PEND, a write that makes the latched winner ineligible drops irq in the next cycle (or switches to the new winner).
- Reset (rst low, asynchronous):
  - State is IDLE; enable, threshold, priorities, cur_id, active ID and err are 0.
  - irq, claim_valid, claim_id, gw_claim and gw_complete are all 0.
  - Reset asserted mid-service abandons the active ID with no gw_complete pulse.

## Timing
- src_ip rising before edge t gives irq=1 after edge t (one-cycle latency from IDLE).
- claim_req sampled at edge t gives claim_valid, claim_id and gw_claim high for exactly the cycle after t; irq=0 after t.
- complete_req sampled at edge t gives gw_complete high for the cycle after t and state IDLE. A still-eligible source re-raises irq after edge t+1.
- Every pulse output is high for exactly one cycle. irq, claim_* and gw_* are all register outputs.
- cfg_rdata is combinational from the registers; a read in the same cycle as a write to the same address returns the old value.

## Test plan
- Basic flow:
  - Setup: enable=0x3, prio[1]=3, threshold=0.
  - Raise src_ip[0] → irq=1 one cycle later.
  - claim_req → claim_id=1, gw_claim=01, irq=0.
  - complete_req id=1 → gw_complete=01, IDLE.
- Priority and tie-break:
  - prio[1]=2, prio[2]=5, both pending → claim_id=2.
  - Set prio[2]=2 → claim_id=1.
- Threshold and enable:
  - threshold=4, prio[1]=4 → irq stays 0; set threshold=3 → irq=1.
  - enable=0x0 while in PEND → irq drops the next cycle.
- Errors:
  - complete_req id=2 while ID 1 is active → no gw_complete, status err=1, still SERV.
  - claim_req in IDLE → claim_valid=1, claim_id=0.
- Boundary:
  - Higher-priority ID 2 arrives during SERV of ID 1 → irq stays 0 until complete.
  - Then irq=1 two cycles after complete_req and claim_id=2.
- Reset:
  - Assert rst low mid-SERV → all outputs 0 immediately, registers cleared.
  - After release, pending sources stay silent until enabled and prioritised.
